// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type and parameter defaults for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ      = 4;
    localparam int DEFAULT_MAX_BURST    = 16;
    localparam int DEFAULT_IDLE_TIMEOUT = 32;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick of the first request at or after ptr
//
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index where the search starts (wraps past N-1 to 0)
//   pick - one-hot winner, all-zero when no request is set
//   idx  - binary index of the winner (0 when none)
//   any  - at least one request is set
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // Walk offsets from farthest to nearest so the nearest request at or
    // after ptr is the last assignment and therefore wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        j    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                pick    = '0;
                pick[j] = 1'b1;
                idx     = j[IW-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding requester bytes into a UART TX FIFO
//
// Ports:
//   clock, reset_n   - system clock, asynchronous active-low reset
//   req_valid/data/last/ready - per-requester byte streams (requester i owns req_data[8i+7:8i])
//   tx_fifo_full     - TX FIFO full, stalls the current owner
//   send, data_in    - TX FIFO write enable and data
//   grant            - one-hot current owner, zero when idle
//   busy             - a grant is held
//   timeout_flag     - one-cycle pulse when a grant is dropped for inactivity
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int MAX_BURST    = DEFAULT_MAX_BURST,
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_fifo_full,
    output logic                 send,
    output logic [7:0]           data_in,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_flag
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state, next_state;
    logic [NUM_REQ-1:0] next_grant;
    logic [IW-1:0]      grant_idx, next_grant_idx;
    logic [IW-1:0]      rr_ptr, next_rr_ptr;
    logic [7:0]         burst_cnt, next_burst_cnt;
    logic [7:0]         stall_cnt, next_stall_cnt;
    logic               next_timeout_flag;

    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               g_valid;
    logic               g_last;
    logic [IW-1:0]      ptr_after_owner;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign g_valid         = req_valid[grant_idx];
    assign g_last          = req_last[grant_idx];
    assign data_in         = req_data[8*grant_idx +: 8];
    assign busy            = (state == GRANTED);
    assign ptr_after_owner = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant        <= '0;
            grant_idx    <= '0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            stall_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= next_state;
            grant        <= next_grant;
            grant_idx    <= next_grant_idx;
            rr_ptr       <= next_rr_ptr;
            burst_cnt    <= next_burst_cnt;
            stall_cnt    <= next_stall_cnt;
            timeout_flag <= next_timeout_flag;
        end
    end

    always_comb begin
        next_state        = state;
        next_grant        = grant;
        next_grant_idx    = grant_idx;
        next_rr_ptr       = rr_ptr;
        next_burst_cnt    = burst_cnt;
        next_stall_cnt    = stall_cnt;
        next_timeout_flag = 1'b0;
        req_ready         = '0;
        send              = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    next_state     = GRANTED;
                    next_grant     = pick;
                    next_grant_idx = pick_idx;
                    next_burst_cnt = '0;
                    next_stall_cnt = '0;
                end
            end

            GRANTED: begin
                req_ready = grant & {NUM_REQ{~tx_fifo_full}};
                send      = g_valid & ~tx_fifo_full;

                if (send) begin
                    next_burst_cnt = burst_cnt + 8'd1;
                    next_stall_cnt = '0;
                    if (g_last || (burst_cnt == 8'(MAX_BURST - 1))) begin
                        next_state  = IDLE;
                        next_grant  = '0;
                        next_rr_ptr = ptr_after_owner;
                    end
                end else if (tx_fifo_full) begin
                    // Backpressure is not inactivity: hold the grant forever.
                    next_stall_cnt = '0;
                end else if (stall_cnt == 8'(IDLE_TIMEOUT - 1)) begin
                    next_state        = IDLE;
                    next_grant        = '0;
                    next_rr_ptr       = ptr_after_owner;
                    next_timeout_flag = 1'b1;
                end else begin
                    next_stall_cnt = stall_cnt + 8'd1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard testbench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int IT = 8;

    logic           clock        = 1'b0;
    logic           reset_n      = 1'b0;
    logic [N-1:0]   req_valid    = '0;
    logic [8*N-1:0] req_data     = '0;
    logic [N-1:0]   req_last     = '0;
    logic [N-1:0]   req_ready;
    logic           tx_fifo_full = 1'b0;
    logic           send;
    logic [7:0]     data_in;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_flag;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_fifo_full (tx_fifo_full),
        .send         (send),
        .data_in      (data_in),
        .grant        (grant),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [7:0] src_data [N][$];
    logic       src_last [N][$];
    int         exp_idx [$];
    logic [7:0] exp_data [$];
    int         grant_log_idx [$];
    int         grant_log_cyc [$];
    int         send_cyc [$];

    int         cyc = 0;
    int         send_count = 0;
    int         last_send_cyc = -100;
    int         timeout_count = 0;
    logic       prev_timeout = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] xfer_s = '0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int first_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Requester models: present the head of each queue, pop on an observed transfer.
    always @(negedge clock) xfer_s <= req_valid & req_ready;

    always @(posedge clock) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer_s[i] && src_data[i].size() > 0) begin
                void'(src_data[i].pop_front());
                void'(src_last[i].pop_front());
            end
            if (src_data[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = src_data[i][0];
                req_last[i]       = src_last[i][0];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (reset_n) begin
            if (grant != '0) check_eq("grant_onehot", $countones(grant), 1);
            if (tx_fifo_full) check_eq("ready_when_full", int'(req_ready), 0);
            if (send) begin
                send_count++;
                last_send_cyc = cyc;
                send_cyc.push_back(cyc);
                check_eq("send_while_full", int'(tx_fifo_full), 0);
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send: actual data=0x%0h grant=%b required no send", data_in, grant);
                end else begin
                    logic [7:0] ed;
                    int ei;
                    ed = exp_data.pop_front();
                    ei = exp_idx.pop_front();
                    check_eq("send_data", int'(data_in), int'(ed));
                    check_eq("send_grant", int'(grant), 1 << ei);
                end
            end
            if (timeout_flag) begin
                timeout_count++;
                check_eq("timeout_delay", cyc - last_send_cyc, IT + 1);
                check_eq("timeout_grant_clear", int'(grant), 0);
                check_eq("timeout_busy", int'(busy), 0);
                if (prev_timeout) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout_pulse_width: actual=2+ cycles required=1 cycle");
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                grant_log_idx.push_back(first_idx(grant));
                grant_log_cyc.push_back(cyc);
            end
            prev_grant   = grant;
            prev_timeout = timeout_flag;
        end else begin
            prev_grant   = '0;
            prev_timeout = 1'b0;
        end
    end

    task automatic add_src(input int i, input logic [7:0] d, input logic l);
        src_data[i].push_back(d);
        src_last[i].push_back(l);
    endtask

    task automatic add_exp(input int i, input logic [7:0] d);
        exp_idx.push_back(i);
        exp_data.push_back(d);
    endtask

    task automatic wait_sends(input int target, input int budget);
        int n;
        n = 0;
        while (send_count < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (send_count < target) check_eq("wait_sends_timeout", send_count, target);
    endtask

    task automatic wait_timeout(input int target, input int budget);
        int n;
        n = 0;
        while (timeout_count < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (timeout_count < target) check_eq("wait_timeout_expired", timeout_count, target);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (busy) check_eq("wait_idle_expired", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int base, glb, t0, sc, tc;

        // Reset state
        repeat (3) @(posedge clock);
        #2;
        check_eq("rst_grant", int'(grant), 0);
        check_eq("rst_send", int'(send), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_ready", int'(req_ready), 0);
        check_eq("rst_timeout", int'(timeout_flag), 0);
        reset_n = 1'b1;

        // Single requester, 3-byte packet
        @(posedge clock); #2;
        base = send_count;
        glb  = grant_log_idx.size();
        add_src(0, 8'h11, 1'b0); add_src(0, 8'h22, 1'b0); add_src(0, 8'h33, 1'b1);
        add_exp(0, 8'h11);       add_exp(0, 8'h22);       add_exp(0, 8'h33);
        @(posedge clock); #2;
        t0 = cyc;
        wait_sends(base + 3, 50);
        check_eq("t1_grant_count", grant_log_idx.size() - glb, 1);
        if (grant_log_idx.size() > glb) begin
            check_eq("t1_grant_idx", grant_log_idx[glb], 0);
            check_eq("t1_grant_latency", grant_log_cyc[glb], t0 + 1);
        end
        if (send_cyc.size() >= base + 3) begin
            check_eq("t1_first_send_latency", send_cyc[base], t0 + 1);
            check_eq("t1_sends_consecutive", send_cyc[base + 2] - send_cyc[base], 2);
        end
        wait_idle(20);
        check_eq("t1_grant_cleared", int'(grant), 0);
        check_eq("t1_rr_ptr", int'(dut.rr_ptr), 1);

        // Reset so contention starts from requester 0
        @(posedge clock); #2 reset_n = 1'b0;
        @(posedge clock); #2 reset_n = 1'b1;

        // Contention: four 1-byte packets
        @(posedge clock); #2;
        base = send_count;
        glb  = grant_log_idx.size();
        for (int i = 0; i < N; i++) begin
            add_src(i, 8'hA0 + 8'(i), 1'b1);
            add_exp(i, 8'hA0 + 8'(i));
        end
        wait_sends(base + 4, 60);
        check_eq("t2_grant_count", grant_log_idx.size() - glb, 4);
        for (int k = 0; k < 4; k++) begin
            if (grant_log_idx.size() > glb + k) begin
                check_eq("t2_grant_order", grant_log_idx[glb + k], k);
                if (k > 0) check_eq("t2_grant_gap", grant_log_cyc[glb + k] - grant_log_cyc[glb + k - 1], 2);
            end
        end
        wait_idle(20);

        // Burst cap: req1 streams 10 bytes, req2 has one packet waiting
        @(posedge clock); #2;
        base = send_count;
        glb  = grant_log_idx.size();
        tc   = timeout_count;
        for (int b = 0; b < 10; b++) add_src(1, 8'hB0 + 8'(b), 1'b0);
        add_src(2, 8'hC0, 1'b1);
        for (int b = 0; b < 4; b++) add_exp(1, 8'hB0 + 8'(b));
        add_exp(2, 8'hC0);
        for (int b = 4; b < 10; b++) add_exp(1, 8'hB0 + 8'(b));
        wait_sends(base + 11, 200);
        wait_timeout(tc + 1, 50);
        check_eq("t3_grant_count", grant_log_idx.size() - glb, 4);
        if (grant_log_idx.size() >= glb + 4) begin
            check_eq("t3_grant0", grant_log_idx[glb], 1);
            check_eq("t3_grant1", grant_log_idx[glb + 1], 2);
            check_eq("t3_grant2", grant_log_idx[glb + 2], 1);
            check_eq("t3_grant3", grant_log_idx[glb + 3], 1);
        end

        // FIFO backpressure mid-packet
        @(posedge clock); #2;
        base = send_count;
        for (int b = 0; b < 5; b++) begin
            add_src(0, 8'hD0 + 8'(b), b == 4);
            add_exp(0, 8'hD0 + 8'(b));
        end
        wait_sends(base + 2, 50);
        @(posedge clock); #2;
        tx_fifo_full = 1'b1;
        sc = send_count;
        tc = timeout_count;
        repeat (5) @(posedge clock);
        #2;
        check_eq("t4_no_send_while_full", send_count, sc);
        check_eq("t4_no_timeout_while_full", timeout_count, tc);
        check_eq("t4_grant_held", int'(grant), 1);
        tx_fifo_full = 1'b0;
        wait_sends(base + 5, 50);
        wait_idle(20);

        // Timeout: req2 sends one byte then goes quiet
        @(posedge clock); #2;
        base = send_count;
        tc   = timeout_count;
        add_src(2, 8'hE0, 1'b0);
        add_exp(2, 8'hE0);
        wait_sends(base + 1, 50);
        wait_timeout(tc + 1, 40);
        check_eq("t5_grant_clear", int'(grant), 0);
        @(negedge clock);
        check_eq("t5_pulse_end", int'(timeout_flag), 0);

        // Reset mid-burst during byte 2 of 4
        @(posedge clock); #2;
        base = send_count;
        for (int b = 0; b < 4; b++) begin
            add_src(3, 8'hF0 + 8'(b), b == 3);
            add_exp(3, 8'hF0 + 8'(b));
        end
        wait_sends(base + 1, 50);
        @(posedge clock); #2;
        check_eq("t6_byte2_in_flight", int'(send), 1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("t6_rst_send", int'(send), 0);
        check_eq("t6_rst_grant", int'(grant), 0);
        check_eq("t6_rst_busy", int'(busy), 0);
        check_eq("t6_rst_ready", int'(req_ready), 0);
        exp_idx.delete();
        exp_data.delete();
        for (int i = 0; i < N; i++) begin
            src_data[i].delete();
            src_last[i].delete();
        end
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        base = send_count;
        glb  = grant_log_idx.size();
        add_src(3, 8'h31, 1'b1);
        add_src(0, 8'h30, 1'b1);
        add_exp(0, 8'h30);
        add_exp(3, 8'h31);
        wait_sends(base + 2, 50);
        check_eq("t6_grant_count", grant_log_idx.size() - glb, 2);
        if (grant_log_idx.size() >= glb + 2) begin
            check_eq("t6_first_after_reset", grant_log_idx[glb], 0);
            check_eq("t6_second_after_reset", grant_log_idx[glb + 1], 3);
        end
        wait_idle(20);

        check_eq("exp_queue_drained", exp_data.size(), 0);
        check_eq("timeout_total", timeout_count, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
